pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and bubble-safe control clearing. It is the generic replacement for the fixed-field stage registers between ID/EXE, EXE/MEM and MEM/WB. Control bits (write enables, source selects) travel separately from the data payload so that a bubble or flush can never fire a stale write enable. An optional skid buffer registers the upstream ready path, so that stall logic does not chain combinationally across stages.

---
 rtl/pipe_stage_reg.sv | 148 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, synchronous flush, control field zeroed when empty.
// Define PIPE_SKID_EN to add a second (skid) entry so that in_ready comes from a register instead of out_ready.
module pipe_stage_reg #(
  parameter int DATA_W      = 64,
  parameter int CTRL_W      = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t                   state;
  state_t                   stateNext;
  logic                     inXfer;
  logic                     outXfer;
  logic                     mainLoad;
  logic [CTRL_W-1:0]        mainCtrlSrc;
  logic [DATA_W-1:0]        mainDataSrc;
  logic [CTRL_W-1:0]        mainCtrl;
  logic [DATA_W-1:0]        mainData;
  logic [STALL_CNT_W-1:0]   stallCnt;

  assign out_valid = (state != EMPTY);
  assign out_ctrl  = mainCtrl;
  assign out_data  = mainData;
  assign stall_cnt = stallCnt;
  assign inXfer    = in_valid && in_ready;
  assign outXfer   = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  logic              skidLoad;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;

  // Ready depends only on the registered state, never on out_ready.
  assign in_ready  = (state != TWO) && !flush;
  assign occupancy = state;

  always_comb begin
    stateNext   = state;
    mainLoad    = 1'b0;
    skidLoad    = 1'b0;
    mainCtrlSrc = in_ctrl;
    mainDataSrc = in_data;
    if (flush) begin
      stateNext = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (inXfer) begin
            stateNext = ONE;
            mainLoad  = 1'b1;
          end
        end
        ONE: begin
          if (inXfer && outXfer) begin
            mainLoad = 1'b1;
          end else if (inXfer) begin
            stateNext = TWO;
            skidLoad  = 1'b1;
          end else if (outXfer) begin
            stateNext = EMPTY;
          end
        end
        TWO: begin
          if (outXfer) begin
            stateNext   = ONE;
            mainLoad    = 1'b1;
            mainCtrlSrc = skidCtrl;
            mainDataSrc = skidData;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skidCtrl <= '0;
      skidData <= '0;
    end else if (skidLoad) begin
      skidCtrl <= in_ctrl;
      skidData <= in_data;
    end
  end
`else
  assign in_ready  = (!out_valid || out_ready) && !flush;
  assign occupancy = {1'b0, state[0]};

  always_comb begin
    stateNext   = state;
    mainLoad    = 1'b0;
    mainCtrlSrc = in_ctrl;
    mainDataSrc = in_data;
    if (flush) begin
      stateNext = EMPTY;
    end else if (inXfer) begin
      stateNext = ONE;
      mainLoad  = 1'b1;
    end else if (outXfer) begin
      stateNext = EMPTY;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      mainCtrl <= '0;
      mainData <= '0;
    end else begin
      state <= stateNext;
      // Control bits die with the entry so a bubble never carries a write enable.
      if (stateNext == EMPTY) begin
        mainCtrl <= '0;
      end else if (mainLoad) begin
        mainCtrl <= mainCtrlSrc;
      end
      if (mainLoad) begin
        mainData <= mainDataSrc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (out_valid && !out_ready && (stallCnt != '1)) begin
      stallCnt <= stallCnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (narrow widths, 4-bit stall counter); handles both PIPE_SKID_EN builds.
module tb_pipe_stage_reg;

  localparam int DATA_W      = 16;
  localparam int CTRL_W      = 4;
  localparam int STALL_CNT_W = 4;

`ifdef PIPE_SKID_EN
  localparam int FULL_OCC    = 2;
  localparam int STALL_BUILD = 2;
  localparam int STALL_FLUSH = 3;
`else
  localparam int FULL_OCC    = 1;
  localparam int STALL_BUILD = 1;
  localparam int STALL_FLUSH = 1;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [CTRL_W-1:0]      in_ctrl;
  logic [DATA_W-1:0]      in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CTRL_W-1:0]      out_ctrl;
  logic [DATA_W-1:0]      out_data;
  logic [1:0]             occupancy;
  logic [STALL_CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_stage_reg #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset values
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ctrl",  32'(out_ctrl),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming at full throughput
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      in_data = DATA_W'(i);
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data",  32'(out_data),  32'(i));
      check("stream_ctrl",  32'(out_ctrl),  32'hF);
      check("stream_occ",   32'(occupancy), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_ctrl",  32'(out_ctrl),  32'd0);
    check("drain_data",  32'(out_data),  32'd8);
    check("drain_occ",   32'(occupancy), 32'd0);
    check("drain_stall", 32'(stall_cnt), 32'd0);

    // Back-pressure build-up and release
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h11;
    in_ctrl   = 4'h1;
    tick();
    check("bp1_occ",  32'(occupancy), 32'd1);
    check("bp1_data", 32'(out_data),  32'h11);
`ifdef PIPE_SKID_EN
    check("bp1_ready", 32'(in_ready), 32'd1);
    in_data = 16'h12;
    in_ctrl = 4'h2;
    tick();
    check("bp2_occ",   32'(occupancy), 32'd2);
    check("bp2_ready", 32'(in_ready),  32'd0);
    check("bp2_data",  32'(out_data),  32'h11);
    check("bp2_ctrl",  32'(out_ctrl),  32'h1);
    in_data = 16'h13;
    in_ctrl = 4'h3;
    tick();
    check("bp3_occ",   32'(occupancy), 32'd2);
    check("bp3_ready", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    #1;
    check("skid_ready_registered", 32'(in_ready), 32'd0);
    tick();
    check("rel1_data",  32'(out_data),  32'h12);
    check("rel1_ctrl",  32'(out_ctrl),  32'h2);
    check("rel1_occ",   32'(occupancy), 32'd1);
    check("rel1_ready", 32'(in_ready),  32'd1);
    tick();
    check("rel2_data", 32'(out_data),  32'h13);
    check("rel2_ctrl", 32'(out_ctrl),  32'h3);
    check("rel2_occ",  32'(occupancy), 32'd1);
`else
    check("bp1_ready", 32'(in_ready), 32'd0);
    in_data = 16'h12;
    in_ctrl = 4'h2;
    tick();
    check("bp2_occ",   32'(occupancy), 32'd1);
    check("bp2_data",  32'(out_data),  32'h11);
    check("bp2_ready", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    #1;
    check("comb_ready_hi", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    #1;
    check("comb_ready_lo", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    check("rel1_data", 32'(out_data), 32'h12);
    check("rel1_ctrl", 32'(out_ctrl), 32'h2);
    in_data = 16'h13;
    in_ctrl = 4'h3;
    tick();
    check("rel2_data", 32'(out_data), 32'h13);
    check("rel2_ctrl", 32'(out_ctrl), 32'h3);
`endif
    in_valid = 1'b0;
    tick();
    check("rel_empty", 32'(out_valid), 32'd0);
    check("bp_stall",  32'(stall_cnt), 32'(STALL_BUILD));

    // Flush while full with a pending input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h21;
    in_ctrl   = 4'h4;
    tick();
`ifdef PIPE_SKID_EN
    in_data = 16'h22;
    tick();
`endif
    check("fl_full_occ", 32'(occupancy), 32'(FULL_OCC));
    flush     = 1'b1;
    in_data   = 16'h23;
    in_ctrl   = 4'h5;
    out_ready = 1'b1;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ctrl",  32'(out_ctrl),  32'd0);
    check("fl_occ",   32'(occupancy), 32'd0);
    check("fl_data",  32'(out_data),  32'h21);
    tick();
    tick();
    check("fl_no_ghost_valid", 32'(out_valid), 32'd0);
    check("fl_no_ghost_occ",   32'(occupancy), 32'd0);
    check("fl_stall",          32'(stall_cnt), 32'(STALL_FLUSH));

    // Stall counter saturation
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h31;
    in_ctrl   = 4'h6;
    tick();
    in_valid = 1'b0;
    check("sat_data", 32'(out_data), 32'h31);
    repeat (5) tick();
    check("sat_mid", 32'(stall_cnt), 32'(STALL_FLUSH + 5));
    repeat (16) tick();
    check("sat_top",   32'(stall_cnt), 32'd15);
    check("sat_valid", 32'(out_valid), 32'd1);
    check("sat_ctrl",  32'(out_ctrl),  32'h6);

    // Asynchronous reset between edges while full
`ifdef PIPE_SKID_EN
    in_valid = 1'b1;
    in_data  = 16'h32;
    in_ctrl  = 4'h7;
    tick();
    in_valid = 1'b0;
`endif
    check("ar_full_occ", 32'(occupancy), 32'(FULL_OCC));
    #3 rst = 1'b1;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_ctrl",  32'(out_ctrl),  32'd0);
    check("ar_out_data",  32'(out_data),  32'd0);
    check("ar_occupancy", 32'(occupancy), 32'd0);
    check("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("ar_in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
